// File: rtl/trace_capture.sv
// trace_capture: circular-buffer recorder for retired-instruction strobes.
// Records {pc, inst, rd, stamp} while ARMED, then drains oldest-first in DONE.
module trace_capture #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16,
  parameter int TIMEOUT = 100,
  parameter bit WRAP    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     trace_valid_i,
  input  logic [XLEN-1:0]          trace_pc_i,
  input  logic [31:0]              trace_inst_i,
  input  logic [4:0]               trace_rd_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [31:0]              out_inst_o,
  output logic [4:0]               out_rd_o,
  output logic [CYCLE_W-1:0]       out_stamp_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     capturing_o,
  output logic                     overflow_o,
  output logic [1:0]               done_cause_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [31:0]        inst;
    logic [4:0]         rd;
    logic [CYCLE_W-1:0] stamp;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head;
  state_e             state_q, state_d;
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         cause_q, cause_d;
  logic               we;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    cyc_d   = cyc_q;
    idle_d  = idle_q;
    ovf_d   = ovf_q;
    cause_d = cause_q;
    we      = 1'b0;
    unique case (state_q)
      S_ARMED: begin
        cyc_d  = cyc_q + CYCLE_W'(1);
        idle_d = trace_valid_i ? '0 : idle_q + IW'(1);
        if (trace_valid_i) begin
          we   = 1'b1;
          wr_d = wr_q + AW'(1);
          if (count_q != FULL) count_d = count_q + CW'(1);
          else begin
            // Full with WRAP: the slot just written was the oldest, so drop it.
            rd_d  = rd_q + AW'(1);
            ovf_d = 1'b1;
          end
        end
        // Capture above is already accounted for; pick the done cause by precedence.
        if (stop_i) begin
          state_d = S_DONE;
          cause_d = 2'd1;
        end else if (!WRAP && trace_valid_i && count_q == FULL - CW'(1)) begin
          state_d = S_DONE;
          cause_d = 2'd2;
        end else if (TIMEOUT != 0 && !trace_valid_i && idle_q == IDLE_LAST) begin
          state_d = S_DONE;
          cause_d = 2'd3;
        end
      end
      S_DONE: begin
        if (count_q != '0 && out_ready_i) begin
          rd_d    = rd_q + AW'(1);
          count_d = count_q - CW'(1);
        end
      end
      default: ;
    endcase
    if (arm_i) begin
      state_d = S_ARMED;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      cyc_d   = '0;
      idle_d  = '0;
      ovf_d   = 1'b0;
      cause_d = '0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cyc_q   <= '0;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      cyc_q   <= cyc_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
      cause_q <= cause_d;
    end
  end

  // Storage carries no reset; entries are only observable once counted.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_q] <= {trace_pc_i, trace_inst_i, trace_rd_i, cyc_q};
  end

  assign head         = mem_q[rd_q];
  assign out_valid_o  = (state_q == S_DONE) && (count_q != '0);
  assign out_pc_o     = head.pc;
  assign out_inst_o   = head.inst;
  assign out_rd_o     = head.rd;
  assign out_stamp_o  = head.stamp;
  assign count_o      = count_q;
  assign capturing_o  = (state_q == S_ARMED);
  assign overflow_o   = ovf_q;
  assign done_cause_o = cause_q;
endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: three configs (wrap, stop-on-full, watchdog) share stimulus
// and are compared against a queue-based reference model.
module tb_trace_capture;
  localparam int NI = 3;
  localparam int D  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [15:0] stamp;
  } rec_t;

  logic clk = 1'b0, rst = 1'b0, arm = 1'b0, stop = 1'b0, tv = 1'b0, ready = 1'b0;
  logic [31:0] pc = '0, inst = '0;
  logic [4:0]  rd = '0;

  logic        ov   [NI];
  logic [31:0] opc  [NI];
  logic [31:0] oinst[NI];
  logic [4:0]  ord  [NI];
  logic [15:0] ost  [NI];
  logic [2:0]  cnt  [NI];
  logic        capt [NI];
  logic        ovf  [NI];
  logic [1:0]  cause[NI];

  int checks = 0, errors = 0;

  // Reference model: per config, a record list [mh, mt) plus state/cause flags.
  int   mst [NI], mh [NI], mt [NI], mcyc [NI], midle [NI], mcause [NI];
  bit   movf [NI];
  rec_t mq [NI][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    trace_capture #(
      .XLEN(32), .DEPTH(D), .CYCLE_W(16),
      .TIMEOUT((g == 2) ? 8 : 0), .WRAP((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_i(stop),
      .trace_valid_i(tv), .trace_pc_i(pc), .trace_inst_i(inst), .trace_rd_i(rd),
      .out_valid_o(ov[g]), .out_ready_i(ready),
      .out_pc_o(opc[g]), .out_inst_o(oinst[g]), .out_rd_o(ord[g]), .out_stamp_o(ost[g]),
      .count_o(cnt[g]), .capturing_o(capt[g]), .overflow_o(ovf[g]), .done_cause_o(cause[g])
    );
  end

  function automatic int to_of(int k);
    return (k == 2) ? 8 : 0;
  endfunction

  function automatic bit wrap_of(int k);
    return k != 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mst[k] = 0; mh[k] = 0; mt[k] = 0; mcyc[k] = 0; midle[k] = 0; mcause[k] = 0; movf[k] = 0;
    end
  endtask

  task automatic model_step();
    rec_t r;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mst[k] = 0; mh[k] = 0; mt[k] = 0; mcyc[k] = 0; midle[k] = 0; mcause[k] = 0; movf[k] = 0;
      end else if (arm) begin
        mst[k] = 1; mh[k] = 0; mt[k] = 0; mcyc[k] = 0; midle[k] = 0; mcause[k] = 0; movf[k] = 0;
      end else if (mst[k] == 1) begin
        if (tv) begin
          r.pc = pc; r.inst = inst; r.rd = rd; r.stamp = 16'(mcyc[k]);
          mq[k][mt[k] % 256] = r;
          mt[k]++;
          if (mt[k] - mh[k] > D) begin mh[k]++; movf[k] = 1; end
          midle[k] = 0;
        end else midle[k]++;
        mcyc[k] = (mcyc[k] + 1) % 65536;
        if (stop) begin mst[k] = 2; mcause[k] = 1; end
        else if (!wrap_of(k) && tv && mt[k] - mh[k] == D) begin mst[k] = 2; mcause[k] = 2; end
        else if (to_of(k) != 0 && midle[k] == to_of(k)) begin mst[k] = 2; mcause[k] = 3; end
      end else if (mst[k] == 2) begin
        if (mt[k] > mh[k] && ready) mh[k]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rec(input logic [31:0] p);
    tv = 1'b1; pc = p; inst = $urandom; rd = 5'($urandom);
    tick();
    tv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (cnt[k] !== 3'd0 || capt[k] !== 1'b0 || ovf[k] !== 1'b0 || cause[k] !== 2'd0 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: got cnt=%0d cap=%0b ovf=%0b cause=%0d vld=%0b, want all 0",
                 k, cnt[k], capt[k], ovf[k], cause[k], ov[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (capt[0] !== 1'b1 || cnt[0] !== 3'd0) begin
      errors++; $display("FAIL basic_arm: got cap=%0b cnt=%0d, want 1 0", capt[0], cnt[0]);
    end
    for (int i = 0; i < 3; i++) rec(32'(4 * i));
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (cause[0] !== 2'd1 || cnt[0] !== 3'd3 || capt[0] !== 1'b0) begin
      errors++; $display("FAIL basic_stop: got cause=%0d cnt=%0d cap=%0b, want 1 3 0", cause[0], cnt[0], capt[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || opc[0] !== 32'(4 * i) || ost[0] !== 16'(i)) begin
        errors++; $display("FAIL basic_read%0d: got vld=%0b pc=%0h stamp=%0d, want 1 %0h %0d",
                           i, ov[0], opc[0], ost[0], 4 * i, i);
      end
      ready = 1'b1; tick(); ready = 1'b0;
    end
    checks++;
    if (ov[0] !== 1'b0 || cnt[0] !== 3'd0) begin
      errors++; $display("FAIL basic_empty: got vld=%0b cnt=%0d, want 0 0", ov[0], cnt[0]);
    end
  endtask

  task automatic test_wrap();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) rec(32'(4 * i));
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (ovf[0] !== 1'b1 || cnt[0] !== 3'd4 || cause[0] !== 2'd1) begin
      errors++; $display("FAIL wrap_status: got ovf=%0b cnt=%0d cause=%0d, want 1 4 1", ovf[0], cnt[0], cause[0]);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[0] !== 1'b1 || opc[0] !== 32'(8 + 4 * i) || ost[0] !== 16'(2 + i)) begin
        errors++; $display("FAIL wrap_read%0d: got vld=%0b pc=%0h stamp=%0d, want 1 %0h %0d",
                           i, ov[0], opc[0], ost[0], 8 + 4 * i, 2 + i);
      end
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic test_full();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rec(32'(4 * i));
      if (i == 3) begin
        checks++;
        if (capt[1] !== 1'b0 || cause[1] !== 2'd2 || cnt[1] !== 3'd4) begin
          errors++; $display("FAIL full_stop: got cap=%0b cause=%0d cnt=%0d, want 0 2 4", capt[1], cause[1], cnt[1]);
        end
      end
    end
    checks++;
    if (cnt[1] !== 3'd4 || ovf[1] !== 1'b0) begin
      errors++; $display("FAIL full_ignore: got cnt=%0d ovf=%0b, want 4 0", cnt[1], ovf[1]);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[1] !== 1'b1 || opc[1] !== 32'(4 * i)) begin
        errors++; $display("FAIL full_read%0d: got vld=%0b pc=%0h, want 1 %0h", i, ov[1], opc[1], 4 * i);
      end
      tick();
    end
    ready = 1'b0;
    checks++;
    if (ov[1] !== 1'b0) begin errors++; $display("FAIL full_drained: got vld=%0b, want 0", ov[1]); end
  endtask

  task automatic test_watchdog();
    arm = 1'b1; tick(); arm = 1'b0;
    rec(32'h100);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        checks++;
        if (capt[2] !== 1'b1) begin errors++; $display("FAIL wd_idle7: got cap=%0b, want 1", capt[2]); end
      end
    end
    checks++;
    if (capt[2] !== 1'b0 || cause[2] !== 2'd3 || cnt[2] !== 3'd1) begin
      errors++; $display("FAIL wd_fire: got cap=%0b cause=%0d cnt=%0d, want 0 3 1", capt[2], cause[2], cnt[2]);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    rec(32'h200);
    for (int i = 0; i < 7; i++) tick();
    rec(32'h204);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (capt[2] !== 1'b1 || cnt[2] !== 3'd2 || cause[2] !== 2'd0) begin
      errors++; $display("FAIL wd_rearm: got cap=%0b cnt=%0d cause=%0d, want 1 2 0", capt[2], cnt[2], cause[2]);
    end
    tick();
    checks++;
    if (capt[2] !== 1'b0 || cause[2] !== 2'd3) begin
      errors++; $display("FAIL wd_second: got cap=%0b cause=%0d, want 0 3", capt[2], cause[2]);
    end
  endtask

  task automatic test_backpressure();
    bit rs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int idx = 0, expc = 3;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 3; i++) rec(32'h40 + 32'(4 * i));
    stop = 1'b1; tick(); stop = 1'b0;
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (ov[0] !== 1'b1 || opc[0] !== 32'h40 + 32'(4 * idx) || cnt[0] !== 3'(expc)) begin
        errors++; $display("FAIL bp_step%0d: got vld=%0b pc=%0h cnt=%0d, want 1 %0h %0d",
                           s, ov[0], opc[0], cnt[0], 32'h40 + 4 * idx, expc);
      end
      ready = rs[s]; tick();
      if (rs[s]) begin idx++; expc--; end
    end
    ready = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || cnt[0] !== 3'd0) begin
      errors++; $display("FAIL bp_end: got vld=%0b cnt=%0d, want 0 0", ov[0], cnt[0]);
    end
  endtask

  task automatic test_simul();
    arm = 1'b1; tick(); arm = 1'b0;
    rec(32'h10); rec(32'h14);
    stop = 1'b1; rec(32'h100); stop = 1'b0;
    checks++;
    if (cause[0] !== 2'd1 || cnt[0] !== 3'd3 || capt[0] !== 1'b0) begin
      errors++; $display("FAIL simul_stop: got cause=%0d cnt=%0d cap=%0b, want 1 3 0", cause[0], cnt[0], capt[0]);
    end
    ready = 1'b1; tick();
    arm = 1'b1; tick(); arm = 1'b0; ready = 1'b0;
    checks++;
    if (cnt[0] !== 3'd0 || capt[0] !== 1'b1 || ov[0] !== 1'b0 || cause[0] !== 2'd0 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL simul_rearm: got cnt=%0d cap=%0b vld=%0b cause=%0d ovf=%0b, want 0 1 0 0 0",
                         cnt[0], capt[0], ov[0], cause[0], ovf[0]);
    end
    rec(32'h20); rec(32'h24);
    rst = 1'b1; #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (cnt[k] !== 3'd0 || capt[k] !== 1'b0 || ovf[k] !== 1'b0 || cause[k] !== 2'd0 || ov[k] !== 1'b0) begin
        errors++; $display("FAIL simul_rst inst%0d: got cnt=%0d cap=%0b ovf=%0b cause=%0d vld=%0b, want all 0",
                           k, cnt[k], capt[k], ovf[k], cause[k], ov[k]);
      end
    end
    rst = 1'b0;
    rec(32'h30);
    checks++;
    if (cnt[0] !== 3'd0 || capt[0] !== 1'b0) begin
      errors++; $display("FAIL simul_idle: got cnt=%0d cap=%0b, want 0 0", cnt[0], capt[0]);
    end
  endtask

  task automatic test_random();
    int rate = 8;
    rec_t e;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) rate = $urandom_range(0, 12);
      arm   = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      tv    = ($urandom_range(0, 15) < rate);
      pc    = $urandom; inst = $urandom; rd = 5'($urandom);
      ready = 1'($urandom_range(0, 1));
      tick();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; #1;
        model_reset();
      end
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (cnt[k] !== 3'(mt[k] - mh[k]) || capt[k] !== (mst[k] == 1) || ovf[k] !== movf[k] ||
            cause[k] !== 2'(mcause[k]) || ov[k] !== (mst[k] == 2 && mt[k] > mh[k])) begin
          errors++;
          $display("FAIL rand_status inst%0d c%0d: got cnt=%0d cap=%0b ovf=%0b cause=%0d vld=%0b, want %0d %0b %0b %0d %0b",
                   k, c, cnt[k], capt[k], ovf[k], cause[k], ov[k],
                   mt[k] - mh[k], mst[k] == 1, movf[k], mcause[k], mst[k] == 2 && mt[k] > mh[k]);
        end
        if (mst[k] == 2 && mt[k] > mh[k]) begin
          e = mq[k][mh[k] % 256];
          checks++;
          if (opc[k] !== e.pc || oinst[k] !== e.inst || ord[k] !== e.rd || ost[k] !== e.stamp) begin
            errors++;
            $display("FAIL rand_entry inst%0d c%0d: got pc=%0h inst=%0h rd=%0d st=%0d, want %0h %0h %0d %0d",
                     k, c, opc[k], oinst[k], ord[k], ost[k], e.pc, e.inst, e.rd, e.stamp);
          end
        end
      end
      rst = 1'b0;
    end
    arm = 1'b0; stop = 1'b0; tv = 1'b0; ready = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_watchdog();
    test_backpressure();
    test_simul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
# trace_capture

Parametrised hardware trace capture unit for the ChronosCore fetch/decode path. It records one entry per retired-instruction strobe (pc, instruction word, rd, cycle stamp) into a circular buffer. A watchdog ends capture after a configurable number of idle cycles. Captured entries drain oldest-first through a valid/ready port. It sits beside the core as a debug/verification peripheral, so traces can be captured in silicon or FPGA without a simulator.

## Interface
- `XLEN`, 32, pc width
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `CYCLE_W`, 16, cycle-stamp width; ≥8
- `TIMEOUT`, 100, idle cycles before a watchdog stop; 0 disables the watchdog
- `WRAP`, 1, 1 = overwrite oldest entry when full; 0 = stop capture when full
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `arm`  in  1  pulse: clear the buffer and start capture
- `stop`  in  1  pulse: end capture
- `trace_valid`  in  1  one record presented this cycle
- `trace_pc`  in  XLEN  pc of the record
- `trace_inst`  in  32  instruction word
- `trace_rd`  in  5  destination register
- `out_valid`  out  1  a readout entry is available
- `out_ready`  in  1  consumer accepts the entry
- `out_pc` / `out_inst` / `out_rd` / `out_stamp`  out  XLEN/32/5/CYCLE_W  readout entry
- `count`  out  $clog2(DEPTH)+1  entries held
- `capturing`  out  1  state == ARMED
- `overflow`  out  1  sticky: at least one entry was overwritten
- `done_cause`  out  2  0 = none, 1 = stop, 2 = full, 3 = timeout

## Operation
- States: IDLE, ARMED, DONE.
- On reset: state IDLE, `count`=0, pointers 0, cycle and idle counters 0, `overflow`=0, `done_cause`=0, `out_valid`=0. Buffer contents are undefined.
- **arm, any state:**
  - Next state is ARMED.
  - Clears `count`, both pointers, the cycle counter, the idle counter, `overflow` and `done_cause`.
  - Any `trace_valid` in the same cycle is ignored.
  - Unread entries in DONE are discarded.
- **ARMED, cycle counter:** increments every cycle and wraps modulo 2^CYCLE_W. The stamp stored with a record is the counter value in its capture cycle. The first cycle after arm has stamp 0.
- **ARMED, trace_valid=1:**
  - Writes {pc, inst, rd, stamp} at wr_ptr, then wr_ptr+1 mod DEPTH.
  - If `count`<DEPTH: `count`+1.
  - Else, WRAP=1: rd_ptr+1 and `overflow`=1; `count` stays at DEPTH.
  - WRAP=0: the write that brings `count` to DEPTH also moves the state to DONE with cause 2. No entry is ever overwritten.
- **ARMED, idle counter:** cleared by `trace_valid`, otherwise incremented. When TIMEOUT≠0 and the TIMEOUT-th consecutive idle cycle occurs, the state moves to DONE with cause 3.
- **ARMED, stop:** next state is DONE with cause 1. A `trace_valid` in the same cycle is still captured.
- **Cause precedence** for a single cycle: arm > stop > full > timeout. The capture happens before the cause is evaluated.
- **IDLE:** `trace_valid` and `stop` are ignored.
- **DONE, readout:**
  - `out_valid` = (`count`≠0).
  - `out_*` show the entry at rd_ptr (oldest).
  - On `out_valid`&&`out_ready`: rd_ptr+1 mod DEPTH, `count`−1.
  - `out_*` hold stable while `out_valid`&&!`out_ready`.
  - `trace_valid` and `stop` are ignored.
- `out_valid` is 0 in IDLE and ARMED.

## Timing
- Capture: a record presented at edge N is counted in `count` after edge N.
- State change: a transition decided in cycle N is visible after edge N. `capturing` is registered.
- Readout: `out_*` are combinational from the buffer and pointers, with zero-cycle latency after entering DONE. Sustained throughput is one entry per cycle with `out_ready`=1.
- Pointer and stamp arithmetic is unsigned modular, so there is no boundary special-casing beyond full/empty.
- Reset asserted mid-capture or mid-readout returns to the reset values immediately (asynchronously). Capture does not resume until the next `arm`.

## Test plan
- **Basic capture** (DEPTH=4, TIMEOUT=0, WRAP=1): arm, 3 records with pc 0x0/0x4/0x8, then stop. Required: `done_cause`=1, `count`=3, and readout pc 0x0, 0x4, 0x8 with stamps 0, 1, 2.
- **Wrap:** arm, 6 consecutive records with pc 0x00 to 0x14, then stop. Required: `overflow`=1, `count`=4, readout pc 0x08, 0x0C, 0x10, 0x14.
- **Stop on full** (WRAP=0): arm, 6 consecutive records. Required: DONE after the 4th record, cause 2, `count`=4; records 5 and 6 are ignored; readout pc 0x00 to 0x0C.
- **Watchdog** (TIMEOUT=8): arm, 1 record, then 8 idle cycles. Required: DONE after the 8th idle edge, cause 3, `count`=1. A second run with 7 idle cycles then a record must stay ARMED.
- **Backpressure:** in DONE with `count`=3, toggle `out_ready` 0,1,0,0,1,1. Required: each entry is held while not ready, `count` steps 3→2→1→0, and `out_valid` drops after the last accept.
- **Simultaneous events and reset:** `stop` with `trace_valid` in the same cycle, then arm during readout, then `rst` pulsed mid-capture. Required: the record is captured with cause 1; arm clears the buffer (`count`=0, ARMED); reset gives IDLE with all outputs 0.
